axi4_lite_accel_regs: RTL and testbench

//  Parametrised AXI4-Lite slave register file fronting a start/done accelerator (e.g. NeuralNetwork).

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi4_lite_accel_ctrl.sv | 91 +++++++++
 rtl/axi4_lite_accel_regs.sv | 192 +++++++++++++++++++
 tb/tb_axi4_lite_accel_regs.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// +--------------------------------------------------------------------------+
// | axi_lite_pkg : response codes, CTRL/STATUS bit map and block offsets       |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

package axi_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_e;

   localparam int CTRL_START_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT    = 1;
   localparam int STATUS_BUSY_BIT    = 0;
   localparam int STATUS_DONE_BIT    = 1;
   localparam int STATUS_OVERRUN_BIT = 2;

   localparam int CTRL_OFS   = 0;
   localparam int STATUS_OFS = 1;
   localparam int RESULT_OFS = 2;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_accel_ctrl.sv
// +--------------------------------------------------------------------------+
// | axi4_lite_accel_ctrl : start pulse, busy/done/overrun, result, irq         |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4_lite_accel_ctrl
   import axi_lite_pkg::*;
#(
   parameter int RESULT_WIDTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ctrl_we_i,
   input  logic                    status_we_i,
   input  logic [2:0]              wbits_i,
   input  logic                    acc_done_i,
   input  logic [RESULT_WIDTH-1:0] acc_result_i,
   output logic                    acc_start_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    overrun_o,
   output logic                    irq_en_o,
   output logic [RESULT_WIDTH-1:0] result_o,
   output logic                    irq_o
);

   logic                    start_q, start_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    ovr_q, ovr_d;
   logic                    irq_en_q, irq_en_d;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    start_req;
   logic                    capture;

   always_comb begin
      start_req = ctrl_we_i && wbits_i[CTRL_START_BIT];
      // Completion in the same cycle as the start pulse belongs to no run.
      capture   = acc_done_i && busy_q && !start_q;
      start_d   = start_req && !busy_q;
      busy_d    = busy_q;
      done_d    = done_q;
      ovr_d     = ovr_q;
      irq_en_d  = irq_en_q;
      result_d  = result_q;

      if (ctrl_we_i) irq_en_d = wbits_i[CTRL_IRQ_EN_BIT];
      if (status_we_i && wbits_i[STATUS_DONE_BIT]) done_d = 1'b0;
      if (status_we_i && wbits_i[STATUS_OVERRUN_BIT]) ovr_d = 1'b0;
      if (start_d) begin
         busy_d = 1'b1;
         done_d = 1'b0;
      end
      if (start_req && busy_q) ovr_d = 1'b1;
      if (capture) begin
         result_d = acc_result_i;
         busy_d   = 1'b0;
         done_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         irq_en_q <= 1'b0;
         result_q <= '0;
      end else begin
         start_q  <= start_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         irq_en_q <= irq_en_d;
         result_q <= result_d;
      end
   end

   assign acc_start_o = start_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign overrun_o   = ovr_q;
   assign irq_en_o    = irq_en_q;
   assign result_o    = result_q;
   assign irq_o       = done_q & irq_en_q;

endmodule

`default_nettype wire

// File: rtl/axi4_lite_accel_regs.sv
// +--------------------------------------------------------------------------+
// | axi4_lite_accel_regs : AXI4-Lite register file fronting an accelerator     |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4_lite_accel_regs
   import axi_lite_pkg::*;
#(
   parameter int ADDRESS      = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int DATA_REGS    = 24,
   parameter int REG_NUM      = 32,
   parameter int RESULT_WIDTH = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [ADDRESS-1:0]              S_AWADDR,
   input  logic                            S_AWVALID,
   output logic                            S_AWREADY,
   input  logic [DATA_WIDTH-1:0]           S_WDATA,
   input  logic [DATA_WIDTH/8-1:0]         S_WSTRB,
   input  logic                            S_WVALID,
   output logic                            S_WREADY,
   output logic [1:0]                      S_BRESP,
   output logic                            S_BVALID,
   input  logic                            S_BREADY,
   input  logic [ADDRESS-1:0]              S_ARADDR,
   input  logic                            S_ARVALID,
   output logic                            S_ARREADY,
   output logic [DATA_WIDTH-1:0]           S_RDATA,
   output logic [1:0]                      S_RRESP,
   output logic                            S_RVALID,
   input  logic                            S_RREADY,
   output logic                            acc_start,
   output logic [DATA_REGS*DATA_WIDTH-1:0] acc_features,
   input  logic                            acc_done,
   input  logic [RESULT_WIDTH-1:0]         acc_result,
   output logic                            irq
);

   localparam int IDX_W      = ADDRESS - 2;
   localparam int STRB_W     = DATA_WIDTH / 8;
   localparam int CTRL_IDX   = DATA_REGS + CTRL_OFS;
   localparam int STATUS_IDX = DATA_REGS + STATUS_OFS;
   localparam int RESULT_IDX = DATA_REGS + RESULT_OFS;

   logic                    aw_full_q, w_full_q, bvalid_q, rvalid_q;
   logic [IDX_W-1:0]        aw_idx_q;
   logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic [1:0]              bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]   regs_q [REG_NUM];

   logic                    wr_commit, wr_in_range, wr_go;
   logic                    ctrl_we, status_we;
   logic [IDX_W-1:0]        ar_idx;
   logic                    rd_in_range;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic                    busy, done, overrun, irq_en;
   logic [RESULT_WIDTH-1:0] result;
   logic                    unused_addr_lsbs;

   assign unused_addr_lsbs = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

   assign S_AWREADY   = !aw_full_q && !bvalid_q;
   assign S_WREADY    = !w_full_q && !bvalid_q;
   assign S_BVALID    = bvalid_q;
   assign S_BRESP     = bresp_q;
   assign S_ARREADY   = !rvalid_q;
   assign S_RVALID    = rvalid_q;
   assign S_RDATA     = rdata_q;
   assign S_RRESP     = rresp_q;

   assign wr_commit   = aw_full_q && w_full_q && !bvalid_q;
   assign wr_in_range = aw_idx_q < IDX_W'(REG_NUM);
   assign wr_go       = wr_commit && wr_in_range;
   assign ctrl_we     = wr_go && (aw_idx_q == IDX_W'(CTRL_IDX)) && wstrb_q[0];
   assign status_we   = wr_go && (aw_idx_q == IDX_W'(STATUS_IDX)) && wstrb_q[0];

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_full_q <= 1'b0;
         w_full_q  <= 1'b0;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (S_AWVALID && S_AWREADY) begin
            aw_full_q <= 1'b1;
            aw_idx_q  <= S_AWADDR[ADDRESS-1:2];
         end
         if (S_WVALID && S_WREADY) begin
            w_full_q <= 1'b1;
            wdata_q  <= S_WDATA;
            wstrb_q  <= S_WSTRB;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && S_BREADY) begin
            bvalid_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
         end
      end
   end

   // CTRL/STATUS/RESULT slots are never written here; they live in the control block.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < REG_NUM; i++) begin
            if ((aw_idx_q == IDX_W'(i)) &&
                (((i < DATA_REGS) && !busy) || (i >= DATA_REGS + 3))) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wstrb_q[b]) regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
               end
            end
         end
      end
   end

   assign ar_idx      = S_ARADDR[ADDRESS-1:2];
   assign rd_in_range = ar_idx < IDX_W'(REG_NUM);

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (ar_idx == IDX_W'(i)) rd_val = regs_q[i];
      end
      if (ar_idx == IDX_W'(CTRL_IDX)) begin
         rd_val = '0;
         rd_val[CTRL_IRQ_EN_BIT] = irq_en;
      end
      if (ar_idx == IDX_W'(STATUS_IDX)) begin
         rd_val = '0;
         rd_val[STATUS_BUSY_BIT]    = busy;
         rd_val[STATUS_DONE_BIT]    = done;
         rd_val[STATUS_OVERRUN_BIT] = overrun;
      end
      if (ar_idx == IDX_W'(RESULT_IDX)) begin
         rd_val = '0;
         rd_val[RESULT_WIDTH-1:0] = result;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (S_ARVALID && !rvalid_q) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_val;
         rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   generate
      for (genvar g = 0; g < DATA_REGS; g++) begin : g_feat
         assign acc_features[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
      end
   endgenerate

   axi4_lite_accel_ctrl #(
      .RESULT_WIDTH (RESULT_WIDTH)
   ) u_ctrl (
      .clk_i        (ACLK),
      .rst_ni       (ARESETN),
      .ctrl_we_i    (ctrl_we),
      .status_we_i  (status_we),
      .wbits_i      (wdata_q[2:0]),
      .acc_done_i   (acc_done),
      .acc_result_i (acc_result),
      .acc_start_o  (acc_start),
      .busy_o       (busy),
      .done_o       (done),
      .overrun_o    (overrun),
      .irq_en_o     (irq_en),
      .result_o     (result),
      .irq_o        (irq)
   );

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_accel_regs.sv
// +--------------------------------------------------------------------------+
// | tb_axi4_lite_accel_regs : directed scoreboard bench for the register file  |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi4_lite_accel_regs;

   localparam int DW   = 32;
   localparam int DR   = 24;
   localparam int RN   = 32;
   localparam int RW   = 4;

   logic              ACLK = 1'b0;
   logic              ARESETN;
   logic [31:0]       S_AWADDR = '0;
   logic              S_AWVALID = 1'b0;
   logic              S_AWREADY;
   logic [DW-1:0]     S_WDATA = '0;
   logic [3:0]        S_WSTRB = '0;
   logic              S_WVALID = 1'b0;
   logic              S_WREADY;
   logic [1:0]        S_BRESP;
   logic              S_BVALID;
   logic              S_BREADY = 1'b0;
   logic [31:0]       S_ARADDR = '0;
   logic              S_ARVALID = 1'b0;
   logic              S_ARREADY;
   logic [DW-1:0]     S_RDATA;
   logic [1:0]        S_RRESP;
   logic              S_RVALID;
   logic              S_RREADY = 1'b0;
   logic              acc_start;
   logic [DR*DW-1:0]  acc_features;
   logic              acc_done = 1'b0;
   logic [RW-1:0]     acc_result = '0;
   logic              irq;

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   int s0;
   logic [1:0]  sb_b [$];
   logic [33:0] sb_r [$];

   axi4_lite_accel_regs #(
      .ADDRESS(32), .DATA_WIDTH(DW), .DATA_REGS(DR), .REG_NUM(RN), .RESULT_WIDTH(RW)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .acc_start(acc_start), .acc_features(acc_features),
      .acc_done(acc_done), .acc_result(acc_result), .irq(irq)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) if (acc_start === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic axi_wr(input int idx, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] exp_resp);
      int  n;
      logic aw_hs, w_hs;
      sb_b.push_back(exp_resp);
      S_AWADDR = idx * 4; S_WDATA = data; S_WSTRB = strb;
      S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b1;
      n = 0;
      while ((S_AWVALID || S_WVALID) && n < 20) begin
         aw_hs = S_AWVALID && S_AWREADY;
         w_hs  = S_WVALID && S_WREADY;
         @(negedge ACLK); n++;
         if (aw_hs) S_AWVALID = 1'b0;
         if (w_hs)  S_WVALID  = 1'b0;
      end
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      n = 0;
      while (!S_BVALID && n < 20) begin @(negedge ACLK); n++; end
      chk("wr_bvalid", 64'(S_BVALID), 64'd1);
      chk("wr_bresp", 64'(S_BRESP), 64'(sb_b.pop_front()));
      @(negedge ACLK);
      S_BREADY = 1'b0;
   endtask

   task automatic axi_rd(input int idx, input logic [31:0] exp_d, input logic [1:0] exp_r);
      int  n;
      logic hs;
      logic [33:0] e;
      sb_r.push_back({exp_d, exp_r});
      S_ARADDR = idx * 4; S_ARVALID = 1'b1; S_RREADY = 1'b1;
      n = 0;
      while (S_ARVALID && n < 20) begin
         hs = S_ARVALID && S_ARREADY;
         @(negedge ACLK); n++;
         if (hs) S_ARVALID = 1'b0;
      end
      S_ARVALID = 1'b0;
      n = 0;
      while (!S_RVALID && n < 20) begin @(negedge ACLK); n++; end
      e = sb_r.pop_front();
      chk("rd_rvalid", 64'(S_RVALID), 64'd1);
      chk($sformatf("rd_data[%0d]", idx), 64'(S_RDATA), 64'(e[33:2]));
      chk($sformatf("rd_resp[%0d]", idx), 64'(S_RRESP), 64'(e[1:0]));
      @(negedge ACLK);
      S_RREADY = 1'b0;
   endtask

   initial begin
      int n;
      // reset state, asserted before any clock edge
      ARESETN = 1'b1;
      #2 ARESETN = 1'b0;
      #1;
      chk("rst_awready", 64'(S_AWREADY), 64'd1);
      chk("rst_wready", 64'(S_WREADY), 64'd1);
      chk("rst_arready", 64'(S_ARREADY), 64'd1);
      chk("rst_bvalid", 64'(S_BVALID), 64'd0);
      chk("rst_rvalid", 64'(S_RVALID), 64'd0);
      chk("rst_rdata", 64'(S_RDATA), 64'd0);
      chk("rst_start", 64'(acc_start), 64'd0);
      chk("rst_irq", 64'(irq), 64'd0);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);

      // 1: byte-strobed write (bytes 0 and 2 of 0xA5A50F0F)
      axi_wr(3, 32'hA5A5_0F0F, 4'b0101, 2'b00);
      axi_rd(3, 32'h00A5_000F, 2'b00);
      chk("feat3", 64'(acc_features[3*DW +: DW]), 64'h00A5_000F);

      // 2: AW three cycles ahead of W, then BREADY held low four cycles
      sb_b.push_back(2'b00);
      S_AWADDR = 7 * 4; S_AWVALID = 1'b1; S_BREADY = 1'b0;
      @(negedge ACLK); S_AWVALID = 1'b0;
      chk("aw_buf_full", 64'(S_AWREADY), 64'd0);
      repeat (2) @(negedge ACLK);
      chk("no_b_before_w", 64'(S_BVALID), 64'd0);
      S_WDATA = 32'h1122_3344; S_WSTRB = 4'hF; S_WVALID = 1'b1;
      @(negedge ACLK); S_WVALID = 1'b0;
      n = 0;
      while (!S_BVALID && n < 20) begin @(negedge ACLK); n++; end
      for (int i = 0; i < 4; i++) begin
         chk("b_held", 64'(S_BVALID), 64'd1);
         @(negedge ACLK);
      end
      chk("b_held_resp", 64'(S_BRESP), 64'(sb_b.pop_front()));
      S_BREADY = 1'b1;
      @(negedge ACLK); S_BREADY = 1'b0;
      chk("b_released", 64'(S_BVALID), 64'd0);
      chk("aw_ready_again", 64'(S_AWREADY), 64'd1);
      axi_rd(7, 32'h1122_3344, 2'b00);

      // 3: out-of-range read and write; idx 37 must not alias onto idx 5
      axi_rd(RN, 32'h0, 2'b10);
      axi_wr(RN + 5, 32'hFFFF_FFFF, 4'hF, 2'b10);
      axi_rd(5, 32'h0, 2'b00);
      axi_rd(3, 32'h00A5_000F, 2'b00);

      // 4: start with irq enabled, completion, W1C of done
      s0 = start_cnt;
      axi_wr(DR, 32'h3, 4'h1, 2'b00);
      chk("start_pulses", 64'(start_cnt - s0), 64'd1);
      axi_rd(DR + 1, 32'h1, 2'b00);
      axi_rd(DR, 32'h2, 2'b00);
      chk("irq_busy", 64'(irq), 64'd0);
      acc_done = 1'b1; acc_result = 4'd7;
      @(negedge ACLK);
      acc_done = 1'b0; acc_result = 4'd0;
      axi_rd(DR + 2, 32'h7, 2'b00);
      axi_rd(DR + 1, 32'h2, 2'b00);
      chk("irq_done", 64'(irq), 64'd1);
      acc_done = 1'b1; acc_result = 4'd9;
      @(negedge ACLK);
      acc_done = 1'b0;
      axi_rd(DR + 2, 32'h7, 2'b00);
      axi_wr(DR + 1, 32'h2, 4'h1, 2'b00);
      axi_rd(DR + 1, 32'h0, 2'b00);
      chk("irq_cleared", 64'(irq), 64'd0);

      // 5: start while busy sets overrun; features frozen; scratch still writable
      s0 = start_cnt;
      axi_wr(DR, 32'h1, 4'h1, 2'b00);
      axi_wr(DR, 32'h1, 4'h1, 2'b00);
      chk("start_once", 64'(start_cnt - s0), 64'd1);
      axi_rd(DR + 1, 32'h5, 2'b00);
      axi_wr(0, 32'h0000_1234, 4'hF, 2'b00);
      axi_rd(0, 32'h0, 2'b00);
      axi_wr(28, 32'hDEAD_BEEF, 4'hF, 2'b00);
      axi_rd(28, 32'hDEAD_BEEF, 2'b00);

      // 6: async reset with BVALID pending and accelerator busy
      sb_b.push_back(2'b00);
      S_AWADDR = 29 * 4; S_WDATA = 32'hCAFE_0001; S_WSTRB = 4'hF;
      S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
      @(negedge ACLK); S_AWVALID = 1'b0; S_WVALID = 1'b0;
      n = 0;
      while (!S_BVALID && n < 20) begin @(negedge ACLK); n++; end
      chk("pre_rst_bvalid", 64'(S_BVALID), 64'd1);
      #2 ARESETN = 1'b0;
      #1;
      sb_b.delete();
      chk("arst_bvalid", 64'(S_BVALID), 64'd0);
      chk("arst_awready", 64'(S_AWREADY), 64'd1);
      chk("arst_features", 64'(|acc_features), 64'd0);
      chk("arst_irq", 64'(irq), 64'd0);
      repeat (2) @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      axi_rd(DR + 1, 32'h0, 2'b00);
      axi_rd(29, 32'h0, 2'b00);
      axi_rd(28, 32'h0, 2'b00);
      axi_rd(7, 32'h0, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
